// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: reset flush, load-use bubble, branch squash and halt drain.
// Optional feature macro: HZ_STALL_COUNT_EN enables the saturating 16-bit stall_count register.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk_HZ,
    input  logic        rst_HZ,
    input  logic        run,
    input  logic        halt_req,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        bf0_write,
    output logic        bf0_flush,
    output logic        bf1_flush,
    output logic        bf2_flush,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic       load_use_s;

    assign load_use_s = ex_memread && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (ex_rt == id_rt));

    // State and phase counter register.
    always_ff @(posedge clk_HZ) begin
        if (rst_HZ) begin
            state_r <= ST_INIT;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and output decode; reset forces the INIT output pattern.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pc_write  = 1'b0;
        bf0_write = 1'b0;
        bf0_flush = 1'b0;
        bf1_flush = 1'b0;
        bf2_flush = 1'b0;
        halted    = 1'b0;
        case (state_r)
            ST_INIT: begin
                bf0_flush = 1'b1;
                bf1_flush = 1'b1;
                bf2_flush = 1'b1;
                if (cnt_r == FLUSH_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                pc_write  = 1'b1;
                bf0_write = 1'b1;
                if (branch_taken) begin
                    bf0_flush = 1'b1;
                    bf1_flush = 1'b1;
                    bf2_flush = 1'b1;
                end else if (load_use_s) begin
                    pc_write  = 1'b0;
                    bf0_write = 1'b0;
                    bf1_flush = 1'b1;
                end else if (halt_req) begin
                    state_s = ST_DRAIN;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                bf0_flush = 1'b1;
                // A late branch still redirects the PC so resume starts on the right path.
                if (branch_taken) begin
                    pc_write  = 1'b1;
                    bf1_flush = 1'b1;
                    bf2_flush = 1'b1;
                end else begin
                    pc_write  = 1'b0;
                end
                if (cnt_r == DRAIN_LAST) begin
                    state_s = ST_HALT;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (run) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = 4'd0;
            end
        endcase
        if (rst_HZ) begin
            pc_write  = 1'b0;
            bf0_write = 1'b0;
            bf0_flush = 1'b1;
            bf1_flush = 1'b1;
            bf2_flush = 1'b1;
            halted    = 1'b0;
        end else begin
            halted    = halted;
        end
    end

`ifdef HZ_STALL_COUNT_EN
    logic        stall_s;
    logic [15:0] stall_cnt_r;

    assign stall_s = (state_r == ST_RUN) && !branch_taken && load_use_s;

    // Saturating count of load-use bubbles.
    always_ff @(posedge clk_HZ) begin
        if (rst_HZ) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = rst_HZ ? 16'h0000 : stall_cnt_r;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed steps plus random traffic against a countdown-based reference model.
module tb_hazard_ctrl;

    localparam int FLUSH = 4;
    localparam int DRAIN = 3;

    logic        clk_HZ = 1'b0;
    logic        rst_HZ, run, halt_req, ex_memread, branch_taken;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        pc_write, bf0_write, bf0_flush, bf1_flush, bf2_flush, halted;
    logic [15:0] stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phases expressed as remaining-cycle counters and flags.
    int init_left  = FLUSH;
    int drain_left = 0;
    bit running    = 1'b0;
    bit halted_m   = 1'b0;
    int stalls     = 0;

    hazard_ctrl #(.FLUSH_CYCLES(FLUSH), .DRAIN_CYCLES(DRAIN)) dut (
        .clk_HZ(clk_HZ), .rst_HZ(rst_HZ), .run(run), .halt_req(halt_req),
        .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .pc_write(pc_write), .bf0_write(bf0_write),
        .bf0_flush(bf0_flush), .bf1_flush(bf1_flush), .bf2_flush(bf2_flush),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk_HZ = ~clk_HZ;

    function automatic bit lu();
        return ex_memread && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit e_pc, e_w, e_f0, e_f1, e_f2, e_h;
        logic [15:0] e_sc;
        e_pc = 0; e_w = 0; e_f0 = 0; e_f1 = 0; e_f2 = 0; e_h = 0;
        if (rst_HZ || init_left > 0) begin
            e_f0 = 1; e_f1 = 1; e_f2 = 1;
        end else if (drain_left > 0) begin
            e_f0 = 1; e_pc = branch_taken; e_f1 = branch_taken; e_f2 = branch_taken;
        end else if (halted_m) begin
            e_h = 1;
        end else if (running) begin
            if (branch_taken) begin
                e_pc = 1; e_w = 1; e_f0 = 1; e_f1 = 1; e_f2 = 1;
            end else if (lu()) begin
                e_f1 = 1;
            end else begin
                e_pc = 1; e_w = 1;
            end
        end
`ifdef HZ_STALL_COUNT_EN
        e_sc = rst_HZ ? 16'h0000 : 16'(stalls);
`else
        e_sc = 16'h0000;
`endif
        chk("pc_write",    {15'd0, pc_write},  {15'd0, e_pc});
        chk("bf0_write",   {15'd0, bf0_write}, {15'd0, e_w});
        chk("bf0_flush",   {15'd0, bf0_flush}, {15'd0, e_f0});
        chk("bf1_flush",   {15'd0, bf1_flush}, {15'd0, e_f1});
        chk("bf2_flush",   {15'd0, bf2_flush}, {15'd0, e_f2});
        chk("halted",      {15'd0, halted},    {15'd0, e_h});
        chk("stall_count", stall_count,        e_sc);
    endtask

    task automatic update_model();
        if (rst_HZ) begin
            init_left = FLUSH; drain_left = 0; running = 0; halted_m = 0; stalls = 0;
        end else if (init_left > 0) begin
            init_left--;
        end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) begin
                halted_m = 1; running = 0;
            end
        end else if (halted_m) begin
            if (run) begin
                halted_m = 0; running = 1;
            end
        end else if (running) begin
            if (branch_taken) begin
                stalls = stalls;
            end else if (lu()) begin
                if (stalls < 65535) stalls++;
            end else if (halt_req) begin
                drain_left = DRAIN;
            end
        end else if (run) begin
            running = 1;
        end
    endtask

    task automatic step(input logic r, input logic rn, input logic hr, input logic br,
                        input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ert);
        rst_HZ = r; run = rn; halt_req = hr; branch_taken = br;
        ex_memread = mr; id_rs = rs; id_rt = rt; ex_rt = ert;
        #1;
        check_outputs();
        @(posedge clk_HZ);
        update_model();
        @(negedge clk_HZ);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        // Reset and INIT flush, then IDLE
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle_steps(7);
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle_steps(2);
        // Load-use on rs, no stall for ex_rt=0, load-use on rt
        step(0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
        step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 1, 5'd2, 5'd7, 5'd7);
        step(0, 0, 0, 0, 1, 5'd2, 5'd7, 5'd3);
        // Branch with a simultaneous load-use match
        step(0, 0, 0, 1, 1, 5'd5, 5'd1, 5'd5);
        // Halt together with stall, then a clean halt and drain
        step(0, 0, 1, 0, 1, 5'd4, 5'd1, 5'd4);
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        idle_steps(4);
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle_steps(2);
        // Reset in the middle of DRAIN
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle_steps(1);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle_steps(5);
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        // Reset in the middle of a stall
        step(0, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9);
        step(1, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9);
        idle_steps(5);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
`ifdef HZ_STALL_COUNT_EN
        // Saturation: hold a load-use condition in RUN for more than 65535 cycles
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle_steps(FLUSH);
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 1, 5'd6, 5'd0, 5'd6);
        idle_steps(2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
